mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port memory between the instruction fetch port and the data (LD/ST) port.
- Runs a registered request/ack handshake toward each requester and a held-request/ready handshake toward memory, with wait-state support and a timeout.
- Data accesses take priority. A streak counter guarantees fetch forward progress.
- Sits between fetch/memory stages and the memory controller. The absence of ack is used as the pipeline stall source.

Parameters:
- D_MAX_CONSEC, 4, max consecutive data grants while i_req is pending before fetch is forced (legal range 1..15).
- TIMEOUT, 64, max cycles m_req may wait for m_ready before the access is abandoned (legal range ≥2).
- RESET_RDATA, 32'h0, value of i_rdata/d_rdata after reset.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- i_req  input  1  fetch request; held with i_addr stable until i_ack/i_err
- i_addr  input  32  fetch address
- i_flush  input  1  pending/in-flight fetch no longer wanted (redirect)
- i_rdata  output  32  fetched word, valid while i_ack
- i_ack  output  1  one-cycle fetch completion pulse
- i_err  output  1  one-cycle fetch timeout pulse
- d_req  input  1  data request; held with d_we/d_addr/d_wdata stable until d_ack/d_err
- d_we  input  1  1=store, 0=load
- d_addr  input  32  data address
- d_wdata  input  32  store data
- d_rdata  output  32  load data, valid while d_ack
- d_ack  output  1  one-cycle data completion pulse
- d_err  output  1  one-cycle data timeout pulse
- m_req  output  1  memory request, held until m_ready or timeout
- m_we  output  1  memory write enable
- m_addr  output  32  word address, bits [1:0] forced 0
- m_wdata  output  32  memory write data
- m_rdata  input  32  memory read data, valid when m_ready
- m_ready  input  1  memory completes access this cycle

Behaviour:
- States: IDLE, I_BUSY, D_BUSY, RESP. All outputs are registered.
- Reset (async): state=IDLE; m_req=m_we=0; m_addr=m_wdata=0; i_ack=i_err=d_ack=d_err=0; i_rdata=d_rdata=RESET_RDATA; streak=0; wait counter=0.
- IDLE arbitration, sampled at the clock edge:
  - A fetch is eligible only if i_req=1 and i_flush=0.
  - Data only → D_BUSY. Fetch only → I_BUSY.
  - Both → D_BUSY, unless streak==D_MAX_CONSEC, in which case → I_BUSY.
  - Neither → stay in IDLE.
  - On grant, latch m_we (0 for fetch), m_addr, m_wdata; assert m_req; clear the wait counter.
- Streak counter:
  - Increments on each D grant while i_req=1.
  - Clears on any I grant, or in any IDLE cycle with i_req=0.
  - Saturates at D_MAX_CONSEC.
- BUSY states:
  - m_req is held; address/data do not change.
  - On m_ready=1: capture m_rdata into the granted side's rdata; drop m_req; → RESP with that side's ack=1 next cycle.
  - Stores also ack; d_rdata is then unspecified-but-stable (keep previous value).
- Timeout:
  - The wait counter increments each BUSY cycle with m_ready=0.
  - When it reaches TIMEOUT-1 with m_ready still 0: drop m_req; → RESP with that side's err=1 instead of ack.
  - m_ready in the same cycle wins over timeout.
- Flush:
  - i_flush=1 at any point during I_BUSY marks the access squashed; the flag is sticky until RESP.
  - The memory access still completes (no abort toward memory).
  - In RESP, i_ack and i_err are suppressed. i_rdata is not updated.
- RESP:
  - Lasts exactly one cycle. ack/err pulse here.
  - Requests are ignored this cycle; the requester deasserts or presents its next request.
  - Next state is IDLE.
- Latency: zero-wait access is 3 cycles from IDLE sampling req to the ack pulse (req edge → m_req cycle 1 with m_ready → ack cycle 2). Each memory wait state adds 1 cycle. Peak throughput is one access per 3 cycles.
- Never: m_req asserted in IDLE/RESP; both acks in the same cycle; ack and err on the same side in the same cycle.
- Requester changing address/data before ack: undefined, not checked.
- Reset mid-access drops m_req immediately (async); no ack or err is generated.

Test Plan:
- Fetch i_addr=32'h0000_0103, m_ready high on first m_req cycle, m_rdata=32'hDEAD_BEEF → m_addr=32'h0000_0100, m_we=0; i_ack one cycle, two cycles after req sampled; i_rdata=32'hDEAD_BEEF.
- Store d_addr=32'h40, d_wdata=32'h1234_5678, m_ready after 3 wait cycles → m_we=1, m_req held 4 cycles with stable m_addr/m_wdata; d_ack 1 cycle later; no i_ack.
- i_req and d_req held continuously, D_MAX_CONSEC=4, zero-wait memory → grant sequence D,D,D,D,I,D,D,D,D,I; i_ack every 5th access.
- m_ready never asserted on a load, TIMEOUT=64 → m_req drops after 64 cycles; d_err pulses once, d_ack stays 0; the next request is arbitrated normally.
- Fetch in flight with i_flush pulsed 1 cycle, m_ready after 2 waits → memory access completes; i_ack=0, i_err=0, i_rdata unchanged; IDLE afterwards.
- rst asserted asynchronously mid D_BUSY → m_req=0 and all acks 0 immediately; after release, state is IDLE and a new fetch completes normally.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if : fetch, data and memory handshake bundle for mem_arbiter
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface mem_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_flush;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        i_err;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        d_err;

  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ready;

  // Arbiter side
  modport slave (
    input  i_req, i_addr, i_flush, d_req, d_we, d_addr, d_wdata, m_rdata, m_ready,
    output i_rdata, i_ack, i_err, d_rdata, d_ack, d_err, m_req, m_we, m_addr, m_wdata
  );

  // Requester / memory side
  modport master (
    output i_req, i_addr, i_flush, d_req, d_we, d_addr, d_wdata, m_rdata, m_ready,
    input  i_rdata, i_ack, i_err, d_rdata, d_ack, d_err, m_req, m_we, m_addr, m_wdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter : shares one single-port memory between fetch and data ports
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_arbiter #(
  parameter int unsigned D_MAX_CONSEC = 4,
  parameter int unsigned TIMEOUT      = 64,
  parameter logic [31:0] RESET_RDATA  = 32'h0
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam int unsigned         WAIT_W     = $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0]   WAIT_LAST  = WAIT_W'(TIMEOUT - 1);
  localparam logic [WAIT_W-1:0]   WAIT_ONE   = WAIT_W'(1);
  localparam logic [3:0]          STREAK_MAX = 4'(D_MAX_CONSEC);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t            state_q;
  logic              m_req_q;
  logic              m_we_q;
  logic [31:0]       m_addr_q;
  logic [31:0]       m_wdata_q;
  logic [31:0]       i_rdata_q;
  logic [31:0]       d_rdata_q;
  logic              i_ack_q;
  logic              i_err_q;
  logic              d_ack_q;
  logic              d_err_q;
  logic [3:0]        streak_q;
  logic [WAIT_W-1:0] wait_q;
  logic              squash_q;

  logic fetch_ok;
  logic d_win;
  logic squash_now;
  logic finish_now;

  assign fetch_ok   = bus.i_req && !bus.i_flush;
  // Data wins unless fetch has been starved for the full streak.
  assign d_win      = bus.d_req && !(fetch_ok && (streak_q == STREAK_MAX));
  assign squash_now = squash_q || bus.i_flush;
  assign finish_now = bus.m_ready || (wait_q == WAIT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= RESET_RDATA;
      d_rdata_q <= RESET_RDATA;
      i_ack_q   <= 1'b0;
      i_err_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      d_err_q   <= 1'b0;
      streak_q  <= '0;
      wait_q    <= '0;
      squash_q  <= 1'b0;
    end else begin
      i_ack_q <= 1'b0;
      i_err_q <= 1'b0;
      d_ack_q <= 1'b0;
      d_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!bus.i_req) begin
            streak_q <= '0;
          end
          if (d_win) begin
            state_q   <= D_BUSY;
            m_req_q   <= 1'b1;
            m_we_q    <= bus.d_we;
            m_addr_q  <= bus.d_addr & ~32'h3;
            m_wdata_q <= bus.d_wdata;
            wait_q    <= '0;
            if (bus.i_req && (streak_q != STREAK_MAX)) begin
              streak_q <= streak_q + 4'd1;
            end
          end else if (fetch_ok) begin
            state_q   <= I_BUSY;
            m_req_q   <= 1'b1;
            m_we_q    <= 1'b0;
            m_addr_q  <= bus.i_addr & ~32'h3;
            m_wdata_q <= '0;
            wait_q    <= '0;
            streak_q  <= '0;
            squash_q  <= 1'b0;
          end
        end
        I_BUSY, D_BUSY: begin
          if ((state_q == I_BUSY) && bus.i_flush) begin
            squash_q <= 1'b1;
          end
          if (finish_now) begin
            m_req_q <= 1'b0;
            state_q <= RESP;
            // A ready in the timeout cycle still counts as a completion.
            if (state_q == I_BUSY) begin
              if (!squash_now) begin
                i_ack_q <= bus.m_ready;
                i_err_q <= !bus.m_ready;
                if (bus.m_ready) begin
                  i_rdata_q <= bus.m_rdata;
                end
              end
            end else begin
              d_ack_q <= bus.m_ready;
              d_err_q <= !bus.m_ready;
              if (bus.m_ready && !m_we_q) begin
                d_rdata_q <= bus.m_rdata;
              end
            end
          end else begin
            wait_q <= wait_q + WAIT_ONE;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.m_req   = m_req_q;
  assign bus.m_we    = m_we_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.i_ack   = i_ack_q;
  assign bus.i_err   = i_err_q;
  assign bus.d_ack   = d_ack_q;
  assign bus.d_err   = d_err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter : directed self-checking bench for mem_arbiter
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_arbiter;

  localparam logic [31:0] RST_VAL = 32'hCAFE_0000;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   mem_wait;
  int   wcnt;
  logic [31:0] rd_val;

  mem_arbiter_if bus ();

  mem_arbiter #(
    .D_MAX_CONSEC (4),
    .TIMEOUT      (64),
    .RESET_RDATA  (RST_VAL)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory responder: raises m_ready after mem_wait wait states of m_req.
  initial begin
    bus.m_ready = 1'b0;
    bus.m_rdata = '0;
    wcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.m_req) begin
        if (wcnt == mem_wait) begin
          bus.m_ready = 1'b1;
          bus.m_rdata = rd_val;
        end else begin
          bus.m_ready = 1'b0;
        end
        wcnt++;
      end else begin
        bus.m_ready = 1'b0;
        wcnt = 0;
      end
    end
  end

  initial begin
    int cnt, errs, acks, nacks, both;
    logic [31:0] seq;
    n_checks = 0;
    n_fail   = 0;
    mem_wait = 0;
    rd_val   = '0;
    rst      = 1'b1;
    bus.i_req = 1'b0; bus.i_addr = '0; bus.i_flush = 1'b0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    tick();
    tick();
    check_eq("rst_m_req", {31'b0, bus.m_req}, 32'd0);
    check_eq("rst_acks", {28'b0, bus.i_ack, bus.i_err, bus.d_ack, bus.d_err}, 32'd0);
    check_eq("rst_i_rdata", bus.i_rdata, RST_VAL);
    check_eq("rst_d_rdata", bus.d_rdata, RST_VAL);
    check_eq("rst_m_addr", bus.m_addr, 32'd0);
    rst = 1'b0;
    tick();

    // Zero-wait fetch
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_0103; rd_val = 32'hDEAD_BEEF; mem_wait = 0;
    tick();
    check_eq("f_m_req", {31'b0, bus.m_req}, 32'd1);
    check_eq("f_m_addr", bus.m_addr, 32'h0000_0100);
    check_eq("f_m_we", {31'b0, bus.m_we}, 32'd0);
    tick();
    check_eq("f_i_ack", {31'b0, bus.i_ack}, 32'd1);
    check_eq("f_i_rdata", bus.i_rdata, 32'hDEAD_BEEF);
    check_eq("f_m_req_drop", {31'b0, bus.m_req}, 32'd0);
    bus.i_req = 1'b0;
    tick();
    check_eq("f_i_ack_pulse", {31'b0, bus.i_ack}, 32'd0);

    // Store with 3 wait states
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h40; bus.d_wdata = 32'h1234_5678;
    mem_wait = 3;
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bus.m_req && bus.m_we && bus.m_addr == 32'h40 && bus.m_wdata == 32'h1234_5678) cnt++;
    end
    check_eq("st_hold", cnt, 32'd4);
    tick();
    check_eq("st_d_ack", {31'b0, bus.d_ack}, 32'd1);
    check_eq("st_no_i_ack", {31'b0, bus.i_ack}, 32'd0);
    check_eq("st_m_req_drop", {31'b0, bus.m_req}, 32'd0);
    bus.d_req = 1'b0;
    tick();

    // Both requesters held: fetch forced after 4 data grants
    mem_wait = 0; rd_val = 32'h0BAD_F00D;
    bus.i_req = 1'b1; bus.i_addr = 32'h100;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h80;
    seq = '0; nacks = 0; both = 0;
    for (int k = 0; k < 60 && nacks < 10; k++) begin
      tick();
      if (bus.i_ack && bus.d_ack) both++;
      if (bus.i_ack || bus.d_ack) begin
        if (bus.i_ack) seq[nacks] = 1'b1;
        nacks++;
        if (nacks == 10) begin
          bus.i_req = 1'b0;
          bus.d_req = 1'b0;
        end
      end
    end
    check_eq("arb_count", nacks, 32'd10);
    check_eq("arb_seq", seq, 32'h0000_0210);
    check_eq("arb_both_ack", both, 32'd0);
    tick();
    tick();

    // Load that never completes: timeout
    mem_wait = 1000;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h88;
    cnt = 0; errs = 0; acks = 0;
    for (int k = 0; k < 80; k++) begin
      tick();
      if (bus.m_req) cnt++;
      if (bus.d_ack) acks++;
      if (bus.d_err) begin
        errs++;
        bus.d_req = 1'b0;
      end
    end
    check_eq("to_m_req_cycles", cnt, 32'd64);
    check_eq("to_d_err", errs, 32'd1);
    check_eq("to_d_ack", acks, 32'd0);

    // Normal fetch after timeout
    mem_wait = 0; rd_val = 32'h1111_2222;
    bus.i_req = 1'b1; bus.i_addr = 32'h200;
    tick();
    check_eq("pto_m_addr", bus.m_addr, 32'h200);
    tick();
    check_eq("pto_i_ack", {31'b0, bus.i_ack}, 32'd1);
    check_eq("pto_i_rdata", bus.i_rdata, 32'h1111_2222);
    bus.i_req = 1'b0;
    tick();

    // Flushed fetch: memory still completes, no ack/err
    mem_wait = 2; rd_val = 32'h9999_9999;
    bus.i_req = 1'b1; bus.i_addr = 32'h300;
    tick();
    check_eq("fl_m_req", {31'b0, bus.m_req}, 32'd1);
    cnt = 1; errs = 0; acks = 0;
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0; bus.i_req = 1'b0;
    if (bus.m_req) cnt++;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (bus.m_req) cnt++;
      if (bus.i_ack) acks++;
      if (bus.i_err) errs++;
    end
    check_eq("fl_m_req_cycles", cnt, 32'd3);
    check_eq("fl_no_ack", acks, 32'd0);
    check_eq("fl_no_err", errs, 32'd0);
    check_eq("fl_i_rdata", bus.i_rdata, 32'h1111_2222);

    // Async reset in the middle of a data access
    mem_wait = 1000;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h44;
    tick();
    tick();
    check_eq("ar_busy", {31'b0, bus.m_req}, 32'd1);
    rst = 1'b1;
    #1;
    check_eq("ar_m_req", {31'b0, bus.m_req}, 32'd0);
    check_eq("ar_acks", {28'b0, bus.i_ack, bus.i_err, bus.d_ack, bus.d_err}, 32'd0);
    bus.d_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    mem_wait = 0; rd_val = 32'h5A5A_5A5A;
    bus.i_req = 1'b1; bus.i_addr = 32'h500;
    tick();
    check_eq("ar_f_m_addr", bus.m_addr, 32'h500);
    tick();
    check_eq("ar_f_i_ack", {31'b0, bus.i_ack}, 32'd1);
    check_eq("ar_f_i_rdata", bus.i_rdata, 32'h5A5A_5A5A);
    bus.i_req = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
